// File: rtl/pid_input_avg.sv
// Boxcar moving-average filter ahead of the PID inputs.
// Averages the last 2**L signed samples. The running sum is kept
// incrementally: each accepted sample adds the newest value and
// subtracts the one leaving the window. A flush zeroes the whole
// circular buffer, one entry per cycle, before filtering resumes.
module pid_input_avg #(
   parameter int DW     = 14,
   parameter int MAXLOG = 5
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 en_i,
   input  logic                 clr_i,
   input  logic [2:0]           cfg_log2n_i,
   input  logic signed [DW-1:0] dat_i,
   output logic signed [DW-1:0] dat_o,
   output logic                 busy_o
);

   localparam int DEPTH = 1 << MAXLOG;
   localparam int SW    = DW + MAXLOG;

   typedef enum logic {CLEAR, RUN} state_t;

   state_t                state, state_nxt;
   logic [2:0]            cfg_q;
   logic [2:0]            leff;
   logic [MAXLOG:0]       n_win;
   logic [MAXLOG-1:0]     clr_cnt, wr_ptr, rd_ptr;
   logic signed [SW-1:0]  sum, sum_shf;
   logic signed [DW-1:0]  mem [DEPTH];
   logic                  flush, clear_we, accept, clr_last;

   // Window size follows the registered config. Any mismatch with the
   // live input forces a flush, so the two agree whenever RUN filters.
   assign leff     = (cfg_q > 3'(MAXLOG)) ? 3'(MAXLOG) : cfg_q;
   assign n_win    = (MAXLOG+1)'(1) << leff;
   // Oldest sample in the window. For N = DEPTH this is the slot about
   // to be overwritten, and the async read still returns its old value.
   assign rd_ptr   = wr_ptr - n_win[MAXLOG-1:0];
   assign flush    = clr_i | (cfg_log2n_i != cfg_q);
   assign clr_last = (clr_cnt == MAXLOG'(DEPTH-1));
   assign sum_shf  = sum >>> leff;

   // State register
   always_ff @(posedge clk_i) begin
      if (!rstn_i) state <= CLEAR;
      else         state <= state_nxt;
   end

   // Next-state logic: a flush always restarts the full clear sweep
   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR: if (flush)         state_nxt = CLEAR;
                else if (clr_last) state_nxt = RUN;
         RUN:   if (flush)         state_nxt = CLEAR;
         default:                  state_nxt = CLEAR;
      endcase
   end

   // Control decode: a flush drops any sample offered in the same cycle
   always_comb begin
      clear_we = 1'b0;
      accept   = 1'b0;
      case (state)
         CLEAR:   clear_we = !flush;
         RUN:     accept   = en_i && !flush;
         default: ;
      endcase
   end

   // Sample buffer: no reset, zeroed by the clear sweep instead
   always_ff @(posedge clk_i) begin
      if (clear_we)    mem[clr_cnt] <= '0;
      else if (accept) mem[wr_ptr]  <= dat_i;
   end

   // Datapath: pointers, running sum, registered average, busy flag
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         cfg_q   <= cfg_log2n_i;
         clr_cnt <= '0;
         wr_ptr  <= '0;
         sum     <= '0;
         dat_o   <= '0;
         busy_o  <= 1'b1;
      end else begin
         cfg_q <= cfg_log2n_i;
         if (flush) begin
            clr_cnt <= '0;
            wr_ptr  <= '0;
            sum     <= '0;
            dat_o   <= '0;
            busy_o  <= 1'b1;
         end else if (state == CLEAR) begin
            clr_cnt <= clr_cnt + MAXLOG'(1);
            dat_o   <= '0;
            if (clr_last) busy_o <= 1'b0;
         end else begin
            dat_o <= sum_shf[DW-1:0];
            if (accept) begin
               wr_ptr <= wr_ptr + MAXLOG'(1);
               sum    <= sum + SW'(dat_i) - SW'(mem[rd_ptr]);
            end
         end
      end
   end

endmodule

// File: tb/tb_pid_input_avg.sv
// Bench for pid_input_avg: a queue-based reference model of the
// windowed average is stepped on every clock edge and compared with
// the DUT on the following falling edge.
module tb_pid_input_avg;

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic                en = 1'b0;
   logic                clr = 1'b0;
   logic [2:0]          cfg = 3'd2;
   logic signed [13:0]  din = '0;
   logic signed [13:0]  dat_o;
   logic                busy_o;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int  hist[$];
   int  m_out = 0;
   bit  m_busy = 1'b1;
   int  m_left = 32;
   int  m_cfg_q = 2;

   always #5 clk = ~clk;

   pid_input_avg dut (
      .clk_i(clk), .rstn_i(rstn), .en_i(en), .clr_i(clr),
      .cfg_log2n_i(cfg), .dat_i(din), .dat_o(dat_o), .busy_o(busy_o)
   );

   // floor(mean of the last N accepted samples), missing ones count as 0
   function automatic int window_avg(int l);
      int n, s, q;
      n = 1 << ((l > 5) ? 5 : l);
      s = 0;
      for (int i = 0; i < n && i < hist.size(); i++)
         s += hist[hist.size()-1-i];
      q = s / n;
      if ((s % n) != 0 && s < 0) q -= 1;
      return q;
   endfunction

   task automatic model_edge();
      if (!rstn) begin
         m_busy = 1; m_left = 32; hist.delete(); m_out = 0;
      end else if (clr || int'(cfg) != m_cfg_q) begin
         m_busy = 1; m_left = 32; hist.delete(); m_out = 0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) m_busy = 0;
         m_out = 0;
      end else begin
         m_out = window_avg(m_cfg_q);
         if (en) begin
            hist.push_back(int'(din));
            if (hist.size() > 32) void'(hist.pop_front());
         end
      end
      m_cfg_q = int'(cfg);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_flush();
      clr = 1; step(); clr = 0;
      for (int i = 0; i < 40 && busy_o; i++) step();
      n_tests++;
      if (busy_o !== 1'b0 || m_busy) begin
         n_fail++;
         $display("FAIL flush_done: busy_o=%0b model=%0b want 0", busy_o, m_busy);
      end
   endtask

   task automatic test_reset();
      int nb;
      rstn = 0; cfg = 3'd2;
      step(); step();
      n_tests++;
      if (busy_o !== 1'b1 || dat_o !== 14'sd0) begin
         n_fail++;
         $display("FAIL reset_state: busy_o=%0b dat_o=%0d want 1 0", busy_o, dat_o);
      end
      rstn = 1; en = 1; din = 14'sd1234;   // must be ignored while clearing
      nb = 0;
      for (int i = 0; i < 60 && busy_o; i++) begin
         nb++;
         n_tests++;
         if (dat_o !== 14'sd0) begin
            n_fail++;
            $display("FAIL reset_dat_zero: dat_o=%0d want 0", dat_o);
         end
         step();
      end
      n_tests++;
      if (nb != 32) begin
         n_fail++;
         $display("FAIL reset_busy_len: got %0d cycles want 32", nb);
      end
      en = 0; din = 0;
   endtask

   task automatic test_ramp();
      int expv[6] = '{0, 250, 500, 750, 1000, 1000};
      en = 1; din = 14'sd1000;
      for (int i = 0; i < 6; i++) begin
         step();
         n_tests++;
         if (int'(dat_o) != expv[i] || int'(dat_o) != m_out) begin
            n_fail++;
            $display("FAIL ramp[%0d]: dat_o=%0d want %0d", i, dat_o, expv[i]);
         end
      end
      en = 0;
   endtask

   task automatic test_floor();
      int expv[7] = '{0, -1, -1, -1, -1, 0, 0};
      do_flush();
      en = 1;
      for (int i = 0; i < 7; i++) begin
         din = (i == 0) ? -14'sd1 : 14'sd0;
         step();
         n_tests++;
         if (int'(dat_o) != expv[i] || int'(dat_o) != m_out) begin
            n_fail++;
            $display("FAIL floor[%0d]: dat_o=%0d want %0d", i, dat_o, expv[i]);
         end
      end
      en = 0; cfg = 3'd3;
      do_flush();
      en = 1; din = -14'sd8;
      for (int i = 0; i < 12; i++) step();
      n_tests++;
      if (dat_o !== -14'sd8) begin
         n_fail++;
         $display("FAIL neg_steady: dat_o=%0d want -8", dat_o);
      end
      en = 0;
   endtask

   task automatic test_extremes();
      cfg = 3'd5;
      do_flush();
      en = 1; din = 14'sd8191;
      for (int i = 0; i < 34; i++) begin
         step();
         n_tests++;
         if (int'(dat_o) != m_out) begin
            n_fail++;
            $display("FAIL max_ramp[%0d]: dat_o=%0d want %0d", i, dat_o, m_out);
         end
      end
      n_tests++;
      if (dat_o !== 14'sd8191) begin
         n_fail++;
         $display("FAIL max_steady: dat_o=%0d want 8191", dat_o);
      end
      din = -14'sd8192;
      for (int i = 0; i < 34; i++) step();
      n_tests++;
      if (dat_o !== -14'sd8192) begin
         n_fail++;
         $display("FAIL min_steady: dat_o=%0d want -8192", dat_o);
      end
      en = 0;
   endtask

   task automatic test_en_pattern();
      cfg = 3'd1;
      do_flush();
      din = 14'sd400;
      for (int i = 0; i < 8; i++) begin
         en = (i % 2 == 0);
         step();
         n_tests++;
         if (int'(dat_o) != m_out) begin
            n_fail++;
            $display("FAIL en_pattern[%0d]: dat_o=%0d want %0d", i, dat_o, m_out);
         end
      end
      n_tests++;
      if (dat_o !== 14'sd400) begin
         n_fail++;
         $display("FAIL en_final: dat_o=%0d want 400", dat_o);
      end
      en = 0;
   endtask

   task automatic test_midrun();
      int nb;
      cfg = 3'd2;
      do_flush();
      en = 1;
      for (int i = 0; i < 10; i++) begin
         din = 14'($urandom_range(0, 16383));
         step();
      end
      // window change mid-run
      cfg = 3'd4; en = 1; din = 14'sd500;
      step();
      nb = 0;
      for (int i = 0; i < 60 && busy_o; i++) begin
         nb++;
         n_tests++;
         if (dat_o !== 14'sd0 || int'(dat_o) != m_out) begin
            n_fail++;
            $display("FAIL cfg_flush_dat: dat_o=%0d want 0", dat_o);
         end
         step();
      end
      n_tests++;
      if (nb != 32) begin
         n_fail++;
         $display("FAIL cfg_flush_len: got %0d want 32", nb);
      end
      // re-ramp from zero with N=16
      for (int i = 0; i < 3; i++) step();
      n_tests++;
      if (int'(dat_o) != 62 || m_out != 62) begin
         n_fail++;
         $display("FAIL reramp: dat_o=%0d model=%0d want 62", dat_o, m_out);
      end
      // clr pulse, retriggered 20 cycles into the clear
      clr = 1; step(); clr = 0;
      nb = 0;
      for (int i = 0; i < 200 && busy_o; i++) begin
         nb++;
         clr = (i == 19);
         step();
      end
      clr = 0;
      n_tests++;
      if (nb != 52) begin
         n_fail++;
         $display("FAIL retrigger_len: got %0d want 52", nb);
      end
      en = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         en   = ($urandom_range(0, 3) != 0);
         din  = 14'($urandom_range(0, 16383));
         clr  = ($urandom_range(0, 199) == 0);
         rstn = ($urandom_range(0, 499) != 0);
         if ($urandom_range(0, 149) == 0) cfg = 3'($urandom_range(0, 7));
         step();
         n_tests++;
         if (int'(dat_o) != m_out || busy_o !== m_busy) begin
            n_fail++;
            $display("FAIL random[%0d]: dat_o=%0d busy=%0b want %0d %0b",
                     i, dat_o, busy_o, m_out, m_busy);
         end
      end
      clr = 0; rstn = 1; en = 0;
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_floor();
      test_extremes();
      test_en_pattern();
      test_midrun();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
